// File: rtl/prog_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder_pkg
// Description : Constants and types shared by the program encoder and the
//               instruction decoder. It holds the mnemonic code enum, the
//               7-bit opcodes, the funct3/funct7 codes, the loader FSM state
//               type and helpers that pack each RV32 instruction format.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_encoder_pkg;

  // Mnemonic codes carried on in_op. Codes 18..31 are illegal.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_SLL  = 5'd5,
    OP_ADDI = 5'd6,
    OP_SLLI = 5'd7,
    OP_LD   = 5'd8,
    OP_SD   = 5'd9,
    OP_BEQ  = 5'd10,
    OP_BNE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BGE  = 5'd13,
    OP_JAL  = 5'd14,
    OP_JALR = 5'd15,
    OP_HALT = 5'd16,
    OP_NOP  = 5'd17
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [6:0] c_opc_rtype  = 7'b0110011;
  localparam logic [6:0] c_opc_iarith = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_halt   = 7'b1111111;
  localparam logic [6:0] c_opc_nop    = 7'b0001111;

  localparam logic [2:0] c_f3_add  = 3'b000;
  localparam logic [2:0] c_f3_and  = 3'b111;
  localparam logic [2:0] c_f3_or   = 3'b110;
  localparam logic [2:0] c_f3_sll  = 3'b001;
  localparam logic [2:0] c_f3_ldsd = 3'b011;
  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_sub  = 7'b0100000;
  localparam logic [6:0] c_f7_mul  = 7'b0000001;

  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  // Branch offsets are always even, so bit 0 is not carried.
  function automatic logic [31:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
      input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_encoder_inst_pack.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder_inst_pack
// Description : Combinational instruction packer. Turns symbolic fields into
//               a 32-bit instruction word. It flags unknown mnemonics and
//               immediates that do not fit the target format.
// Ports       : i_op/i_rd/i_rs1/i_rs2/i_imm - symbolic instruction fields
//               o_word    - encoded instruction word
//               o_illegal - op unknown or immediate out of range
// Revision    : 1.0 - initial release
// ============================================================================
module prog_encoder_inst_pack
  import prog_encoder_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  op_e  w_op;
  logic w_fit12;   // signed value fits [-2048, 2047]
  logic w_fit13;   // signed value fits [-4096, 4095]
  logic w_fit21;   // signed value fits [-2^20, 2^20-1]
  logic w_shamt;   // value fits [0, 31]

  assign w_op    = op_e'(i_op);
  // Sign-extension test: every bit above the field's sign bit equals it.
  assign w_fit12 = (i_imm[31:11] == {21{i_imm[11]}});
  assign w_fit13 = (i_imm[31:12] == {20{i_imm[12]}});
  assign w_fit21 = (i_imm[31:20] == {12{i_imm[20]}});
  assign w_shamt = (i_imm[31:5] == 27'd0);

  always_comb begin
    o_word    = 32'd0;
    o_illegal = 1'b0;
    case (w_op)
      OP_ADD:  o_word = pack_r(c_f7_base, i_rs2, i_rs1, c_f3_add, i_rd, c_opc_rtype);
      OP_SUB:  o_word = pack_r(c_f7_sub,  i_rs2, i_rs1, c_f3_add, i_rd, c_opc_rtype);
      OP_MUL:  o_word = pack_r(c_f7_mul,  i_rs2, i_rs1, c_f3_add, i_rd, c_opc_rtype);
      OP_AND:  o_word = pack_r(c_f7_base, i_rs2, i_rs1, c_f3_and, i_rd, c_opc_rtype);
      OP_OR:   o_word = pack_r(c_f7_base, i_rs2, i_rs1, c_f3_or,  i_rd, c_opc_rtype);
      OP_SLL:  o_word = pack_r(c_f7_base, i_rs2, i_rs1, c_f3_sll, i_rd, c_opc_rtype);
      OP_ADDI: begin
        o_word    = pack_i(i_imm[11:0], i_rs1, c_f3_add, i_rd, c_opc_iarith);
        o_illegal = !w_fit12;
      end
      OP_SLLI: begin
        o_word    = pack_i({7'd0, i_imm[4:0]}, i_rs1, c_f3_sll, i_rd, c_opc_iarith);
        o_illegal = !w_shamt;
      end
      OP_LD: begin
        o_word    = pack_i(i_imm[11:0], i_rs1, c_f3_ldsd, i_rd, c_opc_load);
        o_illegal = !w_fit12;
      end
      OP_JALR: begin
        o_word    = pack_i(i_imm[11:0], i_rs1, c_f3_add, i_rd, c_opc_jalr);
        o_illegal = !w_fit12;
      end
      OP_SD: begin
        o_word    = pack_s(i_imm[11:0], i_rs2, i_rs1, c_f3_ldsd, c_opc_store);
        o_illegal = !w_fit12;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        o_word = pack_b(i_imm[12:1], i_rs2, i_rs1,
                        (w_op == OP_BEQ) ? c_f3_beq :
                        (w_op == OP_BNE) ? c_f3_bne :
                        (w_op == OP_BLT) ? c_f3_blt : c_f3_bge,
                        c_opc_branch);
        o_illegal = i_imm[0] || !w_fit13;
      end
      OP_JAL: begin
        o_word    = pack_j(i_imm[20:1], i_rd, c_opc_jal);
        o_illegal = i_imm[0] || !w_fit21;
      end
      OP_HALT: o_word = {25'd0, c_opc_halt};
      OP_NOP:  o_word = {25'd0, c_opc_nop};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/prog_encoder.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder
// Description : Program loader. It accepts symbolic instructions over a
//               valid/ready handshake and encodes each one. The words go to
//               instruction memory at consecutive word addresses starting at
//               BASE_ADDR. Loading stops at HALT or on an illegal instruction.
// Ports       : clk, rst_n         - clock, async active-low reset
//               start              - pulse: restart load at BASE_ADDR
//               in_valid/in_ready  - instruction handshake
//               in_op..in_imm      - symbolic instruction fields
//               imem_we/addr/wdata - instruction memory write port
//               count              - words written since start (saturating)
//               done / err         - HALT written / illegal input, sticky
// Revision    : 1.0 - initial release
// ============================================================================
module prog_encoder
  import prog_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       count,
  output logic              done,
  output logic              err
);

  logic [31:0]       w_word;
  logic              w_illegal;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [15:0]       r_count;
  logic              r_halt;    // word held in WRITE is a HALT
  logic              r_we;
  logic              r_ready;
  logic              r_done;
  logic              r_err;

  prog_encoder_inst_pack u_inst_pack (
    .i_op      (in_op),
    .i_rd      (in_rd),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= BASE_ADDR;
      r_wdata <= 32'd0;
      r_count <= 16'd0;
      r_halt  <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // start wins in every state. A strobe issued in WRITE has already
      // completed this cycle, so restarting never truncates it.
      if (start) begin
        r_state <= ST_RUN;
        r_addr  <= BASE_ADDR;
        r_count <= 16'd0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (in_valid && r_ready) begin
              r_ready <= 1'b0;
              if (w_illegal) begin
                r_state <= ST_ERROR;
                r_err   <= 1'b1;
              end else begin
                r_state <= ST_WRITE;
                r_wdata <= w_word;
                r_halt  <= (in_op == OP_HALT);
                r_we    <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_count != 16'hFFFF) begin
              r_count <= r_count + 16'd1;
            end
            if (r_halt) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end
          end
          ST_IDLE, ST_DONE, ST_ERROR: r_ready <= 1'b0;
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/prog_encoder.md
Name: prog_encoder

Overview:
- Program loader: the write-side counterpart of the instruction decoder.
- Accepts symbolic instructions (mnemonic code, register indices, immediate) over a valid/ready handshake.
- Encodes each one into the 32-bit instruction word format the decoder consumes, and writes it into instruction memory at consecutive word addresses.
- Used by the testbench/boot path to fill instruction memory before the core leaves reset; loading stops at HALT.

Parameters:
- ADDR_W, 32, instruction memory byte-address width
- BASE_ADDR, 0, first write address after start

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a new program load at BASE_ADDR
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields this cycle
- in_op  in  5  mnemonic code; list fixed in shared package
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  signed immediate (byte offset for branch/jump)
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  byte address of write
- imem_wdata  out  32  encoded instruction word
- count  out  16  words written since start
- done  out  1  HALT written; level until next start
- err  out  1  illegal op or immediate out of range; level until next start

Behaviour:
- Reset: state IDLE; all outputs 0; imem_addr=BASE_ADDR.
- States:
  - IDLE: in_ready=0. start -> RUN; addr=BASE_ADDR, count=0, done=0, err=0.
  - RUN: in_ready=1. in_valid&in_ready -> encode and register the word -> WRITE. Illegal field -> ERROR, nothing written.
  - WRITE: imem_we=1 for exactly one cycle with the registered addr/wdata. Next cycle addr+=4 (wraps modulo 2^ADDR_W), count+=1 (saturates at 0xFFFF). Then DONE if the op was HALT, else RUN.
  - DONE: done=1, in_ready=0. start -> RUN with fresh state.
  - ERROR: err=1, in_ready=0. start -> RUN with fresh state.
- Latency and throughput: handshake in cycle N gives imem_we in cycle N+1. Throughput is one word per 2 cycles. in_ready is never high in WRITE.
- start while in RUN or WRITE: an in-flight WRITE still completes its strobe; the state then restarts at BASE_ADDR. start has priority over in_valid in the same cycle.
- rst_n low at any time: immediate return to reset values. A partial write is abandoned with imem_we forced low.
- Opcodes:
  - R-type 0110011; I-arith 0010011; load 0000011; store 0100011.
  - branch 1100011; jal 1101111; jalr 1100111; halt 1111111; nop 0001111.
- Function fields:
  - add/sub/mul: funct3=000 with funct7 0000000/0100000/0000001.
  - and: funct3=111; or: 110; sll: 001; ld and sd: 011.
  - beq 000, bne 001, blt 100, bge 101.
  - slli: funct7=0, shamt=imm[4:0].
- Immediate formats (standard RV32):
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Range checks (fail -> ERROR):
  - I/S immediate must lie in [-2048, 2047].
  - slli immediate must lie in [0, 31].
  - B immediate must be even and in [-4096, 4094].
  - J immediate must be even and in [-2^20, 2^20-2].
- HALT and NOP encode as opcode only, all other bits 0. Unused fields of every format are 0.

Decomposition:
- Shared package: op code enum, 7-bit opcode constants, funct3/funct7 constants, FSM state typedef. The decoder imports the same constants.
- One sub-module, inst_pack: purely combinational fields -> {word, illegal}. The FSM, counters and handshake live in prog_encoder.

Test Plan:
- start; ADD rd=3 rs1=1 rs2=2 -> imem_we at N+1, addr 0x0, wdata 0x002081B3, count=1.
- SUB x5,x6,x7, then BEQ rs1=1 rs2=2 imm=8 -> 0x407302B3 @0x0, 0x00208463 @0x4; in_ready low during each WRITE cycle.
- JAL rd=1 imm=-4 -> 0xFFDFF0EF. SD rs1=1 rs2=2 imm=16 -> 0x0020B823.
- ADDI imm=2048 -> err=1, no imem_we, in_ready=0. A following start clears err and resets addr to 0.
- HALT after 3 words -> wdata 0x0000007F @0xC, done=1, count=4; further in_valid ignored.
- rst_n low during WRITE -> imem_we drops immediately, all outputs 0, state IDLE.
